sized_data_memory: RTL and testbench

Parametrised data memory for the 32-bit pipeline processor's MEM stage. It replaces the fixed 1024-word memory. It adds:
- byte, halfword and word loads and stores, with sign or zero extension on loads
- a registered read with fixed one-cycle latency
- detection of misaligned and out-of-range accesses
- a hardware clear sequence after reset, which holds off requests until the array is zeroed

---
 rtl/sized_data_memory.sv | 193 +++++++++++++++++++
 tb/tb_sized_data_memory.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sized_data_memory.sv
// Byte/half/word data memory for the MEM stage with registered loads, fault
// detection and a post-reset clear sweep. Define DMEM_BYPASS_EN for same-cycle store-to-load forwarding.
module sized_data_memory #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 32,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              fault,
  output logic              ready
);

  localparam int CNT_W = $clog2(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             read_valid_q, read_valid_d;
  logic             fault_q, fault_d;

  logic [31:0]      mem_q [DEPTH];

  logic [1:0]       lane;
  logic [CNT_W-1:0] word_idx;
  logic             in_range;
  logic             aligned;
  logic             req;
  logic             accept;
  logic             reject;

  logic [3:0]       st_be;
  logic [31:0]      st_data;

  logic             mem_we;
  logic [CNT_W-1:0] mem_widx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  logic [31:0]      rd_word;
  logic [31:0]      src_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_val;

  assign ready = (state_q == ST_RUN);

  // Range is checked on the full word index so high address bits cannot alias into the array.
  always_comb begin
    lane     = address[1:0];
    word_idx = CNT_W'(address >> 2);
    in_range = (64'(address) >> 2) < 64'(DEPTH);
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~address[0];
      default: aligned = (address[1:0] == 2'b00);
    endcase
    req    = ready & (read_en | write_en);
    accept = req & aligned & in_range;
    reject = req & ~(aligned & in_range);
  end

  always_comb begin
    case (size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = write_data << {lane, 3'b000};
      end
      SZ_HALF: begin
        st_be   = 4'b0011 << {address[1], 1'b0};
        st_data = write_data << {address[1], 4'b0000};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = write_data;
      end
    endcase
  end

  // The clear sweep shares the single write port with stores; the two never overlap.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_be    = st_be;
    mem_wdata = st_data;
    if (!rst && state_q == ST_CLEAR && CLEAR_ON_RST != 0) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
    end else if (!rst && accept && write_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word  = mem_q[word_idx];
    src_word = rd_word;
`ifdef DMEM_BYPASS_EN
    for (int i = 0; i < 4; i++) begin
      if (write_en && st_be[i]) begin
        src_word[i*8 +: 8] = st_data[i*8 +: 8];
      end
    end
`endif
    ld_byte = 8'(src_word >> {lane, 3'b000});
    ld_half = 16'(src_word >> {address[1], 4'b0000});
    case (size)
      SZ_BYTE: load_val = load_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = load_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = src_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RST == 0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // read_data only changes on a completed load or a rejection; stores leave it holding.
  always_comb begin
    read_valid_d = 1'b0;
    fault_d      = 1'b0;
    read_data_d  = read_data_q;
    if (accept && read_en) begin
      read_valid_d = 1'b1;
      read_data_d  = load_val;
    end else if (reject) begin
      fault_d      = 1'b1;
      read_valid_d = read_en;
      read_data_d  = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory (DEPTH=16): byte-array reference model feeding
// an expected-result queue, popped one cycle after each request.
module tb_sized_data_memory;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        fault;
  logic        ready;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_mem [DEPTH*4];
  logic [31:0] model_rdata;
  int          tests_run = 0;
  int          tests_failed = 0;

  sized_data_memory #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .address(address), .size(size), .load_unsigned(load_unsigned),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .fault(fault), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic modelAligned(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return a[1:0] == 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [5:0]  i;
    logic [15:0] h;
    i = a[5:0];
    case (sz)
      2'b00: return uns ? {24'h0, model_mem[i]} : {{24{model_mem[i][7]}}, model_mem[i]};
      2'b01: begin
        h = {model_mem[i + 6'd1], model_mem[i]};
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {model_mem[i + 6'd3], model_mem[i + 6'd2], model_mem[i + 6'd1], model_mem[i]};
    endcase
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [5:0] i;
    i = a[5:0];
    model_mem[i] = d[7:0];
    if (sz != 2'b00) model_mem[i + 6'd1] = d[15:8];
    if (sz[1]) begin
      model_mem[i + 6'd2] = d[23:16];
      model_mem[i + 6'd3] = d[31:24];
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;
    model_rdata = 32'h0;
    exp_q.delete();
  endtask

  task automatic driveIdle();
    read_en = 1'b0; write_en = 1'b0; address = 32'h0;
    size = 2'b00; load_unsigned = 1'b0; write_data = 32'h0;
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] a, input logic [1:0] sz,
                               input logic uns, input logic [31:0] wd, input string tag);
    exp_t        e;
    exp_t        got;
    logic [31:0] pre;
    e.tag = tag; e.rvalid = 1'b0; e.fault = 1'b0; e.rdata = model_rdata;
    if (re || we) begin
      if (!(modelAligned(a, sz) && a < 32'(DEPTH*4))) begin
        e.fault = 1'b1; e.rvalid = re; e.rdata = 32'h0;
      end else begin
        pre = modelLoad(a, sz, uns);
        if (we) modelStore(a, sz, wd);
        if (re) begin
          e.rvalid = 1'b1;
`ifdef DMEM_BYPASS_EN
          e.rdata = modelLoad(a, sz, uns);
`else
          e.rdata = pre;
`endif
        end
      end
    end
    model_rdata = e.rdata;
    exp_q.push_back(e);
    @(negedge clk);
    read_en = re; write_en = we; address = a; size = sz; load_unsigned = uns; write_data = wd;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'h0, 32'h1);
    end else begin
      got = exp_q.pop_front();
      checkOutput({got.tag, "_rdata"}, read_data, got.rdata);
      checkOutput({got.tag, "_rvalid"}, 32'(read_valid), 32'(got.rvalid));
      checkOutput({got.tag, "_fault"}, 32'(fault), 32'(got.fault));
    end
  endtask

  // Releases reset and counts cycles until ready, poking requests that must be ignored meanwhile.
  task automatic waitReady(input string tag, input int exp_cycles);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    read_en = 1'b1; write_en = 1'b1; address = 32'h4; size = 2'b10; write_data = 32'hDEADBEEF;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      checkOutput({tag, "_ignored_fault"}, 32'(fault), 32'h0);
      checkOutput({tag, "_ignored_rvalid"}, 32'(read_valid), 32'h0);
    end
    checkOutput({tag, "_clear_cycles"}, 32'(n), 32'(exp_cycles));
    @(negedge clk);
    driveIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic        re;
    logic        we;
    driveIdle();
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(ready), 32'h0);
    checkOutput("rst_rvalid", 32'(read_valid), 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    checkOutput("rst_rdata", read_data, 32'h0);

    waitReady("clear1", DEPTH);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 32'(i*4), 2'b10, 1'b0, 32'h0, "clr_ld");

    applyStimulus(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h8899AABB, "sw_10");
    applyStimulus(1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, "lb_13");
    checkOutput("spec_lb_signed", read_data, 32'hFFFFFF88);
    applyStimulus(1'b1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, "lbu_13");
    checkOutput("spec_lbu", read_data, 32'h00000088);
    applyStimulus(1'b1, 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, "lh_10");
    checkOutput("spec_lh_signed", read_data, 32'hFFFFAABB);
    applyStimulus(1'b1, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, "lhu_12");

    applyStimulus(1'b0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h0000005A, "sb_11");
    applyStimulus(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "lw_merged");
    checkOutput("spec_lane_write", read_data, 32'h88995ABB);
    checkOutput("spec_lane_rvalid", 32'(read_valid), 32'h1);

    applyStimulus(1'b1, 1'b0, 32'h03, 2'b01, 1'b0, 32'h0, "lh_misaligned");
    checkOutput("spec_mis_fault", 32'(fault), 32'h1);
    checkOutput("spec_mis_rdata", read_data, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 2'b10, 1'b0, 32'hFFFFFFFF, "sw_out_of_range");
    checkOutput("spec_oor_fault", 32'(fault), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, "lw_0_unchanged");
    applyStimulus(1'b1, 1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, "lw_3c_unchanged");

    applyStimulus(1'b0, 1'b1, 32'h00, 2'b10, 1'b0, 32'h11111111, "sw_0_old");
    applyStimulus(1'b1, 1'b1, 32'h00, 2'b10, 1'b0, 32'h22222222, "rw_same_cycle");
`ifdef DMEM_BYPASS_EN
    checkOutput("spec_rw_bypass", read_data, 32'h22222222);
`else
    checkOutput("spec_rw_rbw", read_data, 32'h11111111);
`endif
    applyStimulus(1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, "lw_0_new");

    applyStimulus(1'b0, 1'b1, 32'h20, 2'b11, 1'b0, 32'hCAFEF00D, "sz11_store");
    applyStimulus(1'b1, 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, "sz11_load");
    applyStimulus(1'b0, 1'b1, 32'h22, 2'b10, 1'b0, 32'h12345678, "sw_misaligned");
    applyStimulus(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "lw_20_unchanged");
    applyStimulus(1'b1, 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, "lbu_21");
    applyStimulus(1'b0, 1'b1, 32'h16, 2'b01, 1'b0, 32'h0000BEEF, "sh_16_hold");
    applyStimulus(1'b0, 1'b0, 32'h00, 2'b00, 1'b0, 32'h0, "idle");
    applyStimulus(1'b1, 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, "lw_14");

    for (int i = 0; i < 60; i++) begin
      a  = 32'($urandom_range(0, 79));
      sz = 2'($urandom_range(0, 3));
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      applyStimulus(re, we, a, sz, 1'($urandom_range(0, 1)), $urandom, "rand");
    end

    // Reset on the same edge as a rejected load must drop the fault pulse.
    @(negedge clk);
    read_en = 1'b1; address = 32'h3; size = 2'b01; rst = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_pending_fault", 32'(fault), 32'h0);
    checkOutput("rst_pending_rvalid", 32'(read_valid), 32'h0);
    checkOutput("rst_pending_ready", 32'(ready), 32'h0);
    checkOutput("rst_pending_rdata", read_data, 32'h0);
    @(negedge clk);
    driveIdle();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midclear_ready", 32'(ready), 32'h0);
    waitReady("clear2", DEPTH);
    applyStimulus(1'b1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, "clr2_lw_4");
    applyStimulus(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "clr2_lw_10");
    applyStimulus(1'b1, 1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, "clr2_lw_3c");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
